float_mul: RTL and testbench

- Single-precision IEEE-754 multiplier with independent valid/ready operand ports A and B and a valid/ready result port O.
- Processes one product at a time: join A and B, multiply, normalise/round, present result, hold until consumed.
- Sits behind stream producers; `busy` lets the surrounding logic detect quiescence (idle = no valids and not busy).

---
 rtl/float_mul.sv | 175 +++++++++++++++++
 tb/tb_float_mul.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/float_mul.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | float_mul: float32 multiplier, joined A/B valid/ready, valid/ready result |
// | Optional: FLOATMUL_SUBNORMAL_EN enables gradual underflow (default FTZ)   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module float_mul (
  input  logic        clk,
  input  logic        rst,
  output logic        busy,
  input  logic        a_valid,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        o_valid,
  output logic [31:0] o_data,
  input  logic        o_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RND  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t             r_state, w_next;
  logic               w_accept;
  logic [31:0]        r_a, r_b, r_out;
  logic               r_sign, r_nan, r_inf, r_zero;
  logic signed [10:0] r_exp;
  logic [47:0]        r_prod;

  assign w_accept = (r_state == S_IDLE) & a_valid & b_valid;
  assign a_ready  = w_accept;
  assign b_ready  = w_accept;
  assign busy     = (r_state != S_IDLE);
  assign o_valid  = (r_state == S_OUT);
  assign o_data   = r_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_MUL;
      S_MUL:   w_next = S_RND;
      S_RND:   w_next = S_OUT;
      S_OUT:   if (o_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand classification
  logic [7:0]  w_ea, w_eb, w_ea_eff, w_eb_eff;
  logic [22:0] w_fa, w_fb;
  logic [23:0] w_ma, w_mb;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  assign w_ea    = r_a[30:23];
  assign w_eb    = r_b[30:23];
  assign w_fa    = r_a[22:0];
  assign w_fb    = r_b[22:0];
  assign w_a_nan = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_nan = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_a_inf = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_b_inf = (w_eb == 8'hFF) && (w_fb == 23'd0);
`ifdef FLOATMUL_SUBNORMAL_EN
  assign w_a_zero = (w_ea == 8'd0) && (w_fa == 23'd0);
  assign w_b_zero = (w_eb == 8'd0) && (w_fb == 23'd0);
  assign w_ma     = {(w_ea != 8'd0), w_fa};
  assign w_mb     = {(w_eb != 8'd0), w_fb};
  assign w_ea_eff = (w_ea == 8'd0) ? 8'd1 : w_ea;
  assign w_eb_eff = (w_eb == 8'd0) ? 8'd1 : w_eb;
`else
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);
  assign w_ma     = {1'b1, w_fa};
  assign w_mb     = {1'b1, w_fb};
  assign w_ea_eff = w_ea;
  assign w_eb_eff = w_eb;
`endif

  // Normalise so the product MSB sits at bit 47; w_en is then the biased exponent
  logic [5:0]         w_lz;
  logic [47:0]        w_pn, w_ps;
  logic signed [10:0] w_en, w_ebase;
  logic               w_lost;

  always_comb begin
    w_lz = 6'd0;
    for (int i = 0; i < 48; i++) begin
      if (r_prod[i]) w_lz = 6'(47 - i);
    end
  end

  assign w_pn = r_prod << w_lz;
  assign w_en = r_exp + 11'sd1 - $signed({5'd0, w_lz});

`ifdef FLOATMUL_SUBNORMAL_EN
  logic        w_tiny;
  logic [10:0] w_rsh_raw;
  logic [5:0]  w_rsh;
  assign w_tiny    = (w_en < 11'sd1);
  assign w_rsh_raw = 11'sd1 - w_en;
  assign w_rsh     = !w_tiny ? 6'd0 : (w_rsh_raw > 11'd48) ? 6'd48 : w_rsh_raw[5:0];
  assign w_ps      = w_pn >> w_rsh;
  assign w_lost    = |(w_pn & ~({48{1'b1}} << w_rsh));
  assign w_ebase   = w_tiny ? 11'sd0 : (w_en - 11'sd1);
`else
  assign w_ps    = w_pn;
  assign w_lost  = 1'b0;
  assign w_ebase = w_en - 11'sd1;
`endif

  // Round to nearest even; the hidden bit and any mantissa carry add into the exponent field
  logic [23:0]        w_mant;
  logic               w_inc, w_of, w_uf;
  logic [24:0]        w_mr;
  logic signed [33:0] w_sum;
  logic [31:0]        w_res;

  assign w_mant = w_ps[47:24];
  assign w_inc  = w_ps[23] & ((|w_ps[22:0]) | w_lost | w_mant[0]);
  assign w_mr   = {1'b0, w_mant} + {24'd0, w_inc};
  assign w_sum  = ($signed({{23{w_ebase[10]}}, w_ebase}) <<< 23) + $signed({9'd0, w_mr});
  assign w_of   = (w_sum >= 34'sd2139095040);
`ifdef FLOATMUL_SUBNORMAL_EN
  assign w_uf   = 1'b0;
`else
  assign w_uf   = (w_sum < 34'sd8388608);
`endif

  always_comb begin
    w_res = {r_sign, w_sum[30:0]};
    if (r_nan)               w_res = 32'h7FC0_0000;
    else if (r_inf || w_of)  w_res = {r_sign, 8'hFF, 23'd0};
    else if (r_zero || w_uf) w_res = {r_sign, 31'd0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= 32'd0;
      r_b    <= 32'd0;
      r_sign <= 1'b0;
      r_nan  <= 1'b0;
      r_inf  <= 1'b0;
      r_zero <= 1'b0;
      r_exp  <= 11'sd0;
      r_prod <= 48'd0;
      r_out  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_a <= a_data;
        r_b <= b_data;
      end
      if (r_state == S_MUL) begin
        r_sign <= r_a[31] ^ r_b[31];
        r_nan  <= w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
        r_inf  <= w_a_inf | w_b_inf;
        r_zero <= w_a_zero | w_b_zero;
        r_exp  <= $signed({3'd0, w_ea_eff}) + $signed({3'd0, w_eb_eff}) - 11'sd127;
        r_prod <= {24'd0, w_ma} * {24'd0, w_mb};
      end
      if (r_state == S_RND) r_out <= w_res;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_float_mul.sv
`default_nettype none
// Bench for float_mul: directed cases plus random operands against an integer
// value-domain model (M * 2^E rounded to float32).
module tb_float_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy;
  logic        a_valid = 1'b0, b_valid = 1'b0, o_ready = 1'b0;
  logic [31:0] a_data = 32'd0, b_data = 32'd0;
  logic        a_ready, b_ready, o_valid;
  logic [31:0] o_data;
  int          checks = 0;
  int          errors = 0;

  float_mul dut (
    .clk(clk), .rst(rst), .busy(busy),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product, then one rounding to the target grid
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s, an, bn, ai, bi, az, bz;
    longint unsigned ma, mb, m, q, rem, half;
    int ea, eb, e, p, lsb, sh, biased;
    s  = a[31] ^ b[31];
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:0] == 0);
    bz = (b[30:0] == 0);
`ifndef FLOATMUL_SUBNORMAL_EN
    if (a[30:23] == 0) az = 1'b1;
    if (b[30:23] == 0) bz = 1'b1;
`endif
    if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC00000;
    if (ai || bi) return {s, 8'hFF, 23'd0};
    if (az || bz) return {s, 31'd0};
    if (a[30:23] == 0) begin ma = 64'(a[22:0]); ea = -149; end
    else begin ma = 64'(a[22:0]) | (64'd1 << 23); ea = int'(a[30:23]) - 150; end
    if (b[30:23] == 0) begin mb = 64'(b[22:0]); eb = -149; end
    else begin mb = 64'(b[22:0]) | (64'd1 << 23); eb = int'(b[30:23]) - 150; end
    m = ma * mb;
    e = ea + eb;
    p = 63;
    while (p > 0 && !m[p]) p--;
    lsb = p + e - 23;
`ifdef FLOATMUL_SUBNORMAL_EN
    if (lsb < -149) lsb = -149;
`endif
    sh = lsb - e;
    if (sh <= 0) q = m << (-sh);
    else if (sh > 62) q = 0;
    else begin
      q    = m >> sh;
      rem  = m & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end
    if (q == (64'd1 << 24)) begin q = 64'd1 << 23; lsb++; end
    if (q >= (64'd1 << 23)) begin
      biased = lsb + 150;
      if (biased >= 255) return {s, 8'hFF, 23'd0};
      if (biased <= 0) return {s, 31'd0};
      return {s, 8'(biased), q[22:0]};
    end
    return {s, 8'd0, q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 15))
      0:       v[30:0]  = 31'd0;
      1:       v[30:0]  = {8'hFF, 23'd0};
      2:       v[30:23] = 8'hFF;
      3:       v[30:23] = 8'd0;
      4:       v[30:23] = 8'($urandom_range(190, 254));
      5:       v[30:23] = 8'($urandom_range(1, 40));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // Present both operands in IDLE and pass the accept edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    a_data = a; b_data = b; a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("join_ready", {30'd0, a_ready, b_ready}, 32'd3);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [31:0] exp, input int hold, input logic pend);
    int lat;
    logic [31:0] got;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 12) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd3);
    chk(tag, o_data, exp);
    got = o_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {o_data[31:2], o_valid, busy}, {got[31:2], 2'b11});
      chk({tag, "_hold_data"}, o_data, got);
      if (pend) chk({tag, "_hold_ready"}, {31'd0, a_ready}, 32'd0);
    end
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    chk({tag, "_release"}, {30'd0, o_valid, busy}, 32'd0);
    if (pend) chk({tag, "_next_ready"}, {30'd0, a_ready, b_ready}, 32'd3);
  endtask

  logic [31:0] da [8] = '{32'h40000000, 32'hBF800000, 32'h3FC00000, 32'h3F800001,
                          32'h7F800000, 32'h7FC00001, 32'h7F7FFFFF, 32'h00800000};
  logic [31:0] db [8] = '{32'h40400000, 32'h40800000, 32'h3FC00000, 32'h3F800001,
                          32'h00000000, 32'h3F800000, 32'h40000000, 32'h3F000000};
  logic [31:0] dx [8] = '{32'h40C00000, 32'hC0800000, 32'h40100000, 32'h3F800002,
                          32'h7FC00000, 32'h7FC00000, 32'h7F800000,
`ifdef FLOATMUL_SUBNORMAL_EN
                          32'h00400000};
`else
                          32'h00000000};
`endif

  initial begin
    logic [31:0] ra, rb;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {29'd0, busy, o_valid, a_ready}, 32'd0);
    chk("reset_data", o_data, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic product with o_ready held high
    o_ready = 1'b1;
    issue(32'h40000000, 32'h40400000);
    collect("basic", 32'h40C00000, 0, 1'b0);

    // Directed value table
    for (int i = 0; i < 8; i++) begin
      issue(da[i], db[i]);
      collect($sformatf("dir%0d", i), dx[i], 0, 1'b0);
    end

    // Join: A alone never gets accepted
    a_data = 32'h3FC00000; b_data = 32'h40000000;
    a_valid = 1'b1; b_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("join_a_only", {29'd0, a_ready, b_ready, busy}, 32'd0);
      @(posedge clk); #1;
    end
    b_valid = 1'b1;
    #1;
    chk("join_both", {30'd0, a_ready, b_ready}, 32'd3);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    collect("join_result", 32'h40400000, 0, 1'b0);

    // Backpressure with the next pair already waiting
    issue(32'h40000000, 32'h40400000);
    a_data = 32'hBF800000; b_data = 32'h40800000;
    a_valid = 1'b1; b_valid = 1'b1;
    collect("bp", 32'h40C00000, 5, 1'b1);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    collect("bp_next", 32'hC0800000, 0, 1'b0);

    // Reset while in MUL drops the operation
    issue(32'h40000000, 32'h40400000);
    rst = 1'b0;
    #1;
    chk("rst_mid_now", {30'd0, o_valid, busy}, 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_data", o_data, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_no_result", {30'd0, o_valid, busy}, 32'd0);
    end
    issue(32'h3FC00000, 32'h3FC00000);
    collect("after_rst", 32'h40100000, 0, 1'b0);

    // Random operands against the reference model
    for (int n = 0; n < 120; n++) begin
      ra = rnd_operand();
      rb = rnd_operand();
      issue(ra, rb);
      collect($sformatf("rand %h*%h", ra, rb), ref_mul(ra, rb), $urandom_range(0, 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
